// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: drives the SA/SB pulse pair at a programmed step interval and direction.
// It also tracks signed position and a per-revolution edge counter that drives the index output.
module quad_encoder_emulator #(
    parameter int STEP_W         = 24,
    parameter int COUNTS_PER_REV = 1440,
    parameter int POS_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic              cfg_dir,
    output logic              SA,
    output logic              SB,
    output logic              index,
    output logic              step_pulse,
    output logic [POS_W-1:0]  position
);

    localparam int CNT_W = $clog2(COUNTS_PER_REV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNTS_PER_REV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [POS_W-1:0]  position_q, position_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [STEP_W-1:0] timer_q, timer_d;
    logic [STEP_W-1:0] act_step_q, act_step_d;
    logic              act_dir_q, act_dir_d;
    logic [STEP_W-1:0] sh_step_q, sh_step_d;
    logic              sh_dir_q, sh_dir_d;
    logic              pending_q, pending_d;
    logic              step_pulse_q, step_pulse_d;

    // Phase is kept as {SA,SB} directly so the outputs are flop outputs.
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic fwd);
        logic [1:0] r;
        if (fwd) begin
            case (ph)
                2'b00:   r = 2'b10;
                2'b10:   r = 2'b11;
                2'b11:   r = 2'b01;
                default: r = 2'b00;
            endcase
        end else begin
            case (ph)
                2'b00:   r = 2'b01;
                2'b01:   r = 2'b11;
                2'b11:   r = 2'b10;
                default: r = 2'b00;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        position_d   = position_q;
        edge_cnt_d   = edge_cnt_q;
        timer_d      = timer_q;
        act_step_d   = act_step_q;
        act_dir_d    = act_dir_q;
        sh_step_d    = sh_step_q;
        sh_dir_d     = sh_dir_q;
        pending_d    = pending_q;
        step_pulse_d = 1'b0;

        if (cfg_valid && !pending_q) begin
            sh_step_d = cfg_step;
            sh_dir_d  = cfg_dir;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    act_step_d = sh_step_q;
                    act_dir_d  = sh_dir_q;
                    pending_d  = 1'b0;
                end
                if (enable && act_step_d != '0) begin
                    state_d = RUN;
                    timer_d = act_step_d - STEP_W'(1);
                end
            end
            default: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    phase_d      = next_phase(phase_q, act_dir_q);
                    step_pulse_d = 1'b1;
                    if (act_dir_q) begin
                        position_d = position_q + POS_W'(1);
                        edge_cnt_d = (edge_cnt_q == CNT_MAX) ? '0 : edge_cnt_q + CNT_W'(1);
                    end else begin
                        position_d = position_q - POS_W'(1);
                        edge_cnt_d = (edge_cnt_q == '0) ? CNT_MAX : edge_cnt_q - CNT_W'(1);
                    end
                    // New rate/direction only takes effect on an interval boundary.
                    if (pending_q) begin
                        act_step_d = sh_step_q;
                        act_dir_d  = sh_dir_q;
                        pending_d  = 1'b0;
                    end
                    timer_d = act_step_d - STEP_W'(1);
                    if (act_step_d == '0) state_d = IDLE;
                end else begin
                    timer_d = timer_q - STEP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            phase_q      <= 2'b00;
            position_q   <= '0;
            edge_cnt_q   <= '0;
            timer_q      <= '0;
            act_step_q   <= '0;
            act_dir_q    <= 1'b1;
            sh_step_q    <= '0;
            sh_dir_q     <= 1'b1;
            pending_q    <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            position_q   <= position_d;
            edge_cnt_q   <= edge_cnt_d;
            timer_q      <= timer_d;
            act_step_q   <= act_step_d;
            act_dir_q    <= act_dir_d;
            sh_step_q    <= sh_step_d;
            sh_dir_q     <= sh_dir_d;
            pending_q    <= pending_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign SA         = phase_q[1];
    assign SB         = phase_q[0];
    assign position   = position_q;
    assign index      = (edge_cnt_q == '0);
    assign step_pulse = step_pulse_q;
    assign cfg_ready  = !pending_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench for quad_encoder_emulator: a per-cycle vector table, then directed multi-cycle sequences.
// Small parameters (8 counts/rev, 4-bit position) make the wrap cases reachable quickly.
module tb_quad_encoder_emulator;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_step = '0;
    logic       cfg_dir = 1'b1;
    logic       cfg_ready, SA, SB, index, step_pulse;
    logic [3:0] position;

    int n_vec = 0;
    int n_err = 0;

    quad_encoder_emulator #(.STEP_W(8), .COUNTS_PER_REV(8), .POS_W(4)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_step(cfg_step), .cfg_dir(cfg_dir),
        .SA(SA), .SB(SB), .index(index), .step_pulse(step_pulse), .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, en, vld;
        logic [7:0] step;
        logic       dir;
        logic       ready, sa, sb, pulse, idx;
        logic [3:0] pos;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(int r, int e, int v, int s, int d,
                                int rd, int a, int b, int p, int ix, int ps);
        vec_t t;
        t.rst_n = 1'(r);  t.en = 1'(e);  t.vld = 1'(v);  t.step = 8'(s);  t.dir = 1'(d);
        t.ready = 1'(rd); t.sa = 1'(a);  t.sb = 1'(b);   t.pulse = 1'(p); t.idx = 1'(ix);
        t.pos = 4'(ps);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic cfg(input int s, input int d);
        int k = 0;
        while (!cfg_ready && k < 50) begin
            tick();
            k++;
        end
        chk("cfg_ready before offer", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1; cfg_step = 8'(s); cfg_dir = 1'(d);
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int c;
        int np;
        // rst en vld step dir | ready sa sb pulse idx pos
        tbl[0]  = mk(0,0,0,0,1, 1,0,0,0,1,0);
        tbl[1]  = mk(1,0,1,4,1, 0,0,0,0,1,0);
        tbl[2]  = mk(1,0,0,0,1, 1,0,0,0,1,0);
        tbl[3]  = mk(1,1,0,0,1, 1,0,0,0,1,0);
        tbl[4]  = mk(1,1,0,0,1, 1,0,0,0,1,0);
        tbl[5]  = mk(1,1,0,0,1, 1,0,0,0,1,0);
        tbl[6]  = mk(1,1,0,0,1, 1,0,0,0,1,0);
        tbl[7]  = mk(1,1,0,0,1, 1,1,0,1,0,1);
        tbl[8]  = mk(1,1,0,0,1, 1,1,0,0,0,1);
        tbl[9]  = mk(1,1,0,0,1, 1,1,0,0,0,1);
        tbl[10] = mk(1,1,0,0,1, 1,1,0,0,0,1);
        tbl[11] = mk(1,1,0,0,1, 1,1,1,1,0,2);
        tbl[12] = mk(1,1,0,0,1, 1,1,1,0,0,2);
        tbl[13] = mk(1,1,0,0,1, 1,1,1,0,0,2);
        tbl[14] = mk(1,1,0,0,1, 1,1,1,0,0,2);
        tbl[15] = mk(1,1,0,0,1, 1,0,1,1,0,3);
        tbl[16] = mk(1,1,0,0,1, 1,0,1,0,0,3);
        tbl[17] = mk(1,1,0,0,1, 1,0,1,0,0,3);
        tbl[18] = mk(1,1,0,0,1, 1,0,1,0,0,3);
        tbl[19] = mk(1,1,0,0,1, 1,0,0,1,0,4);
        tbl[20] = mk(1,1,1,2,0, 0,0,0,0,0,4);
        tbl[21] = mk(1,1,0,0,1, 0,0,0,0,0,4);
        tbl[22] = mk(1,1,0,0,1, 0,0,0,0,0,4);
        tbl[23] = mk(1,1,0,0,1, 1,1,0,1,0,5);
        tbl[24] = mk(1,1,0,0,1, 1,1,0,0,0,5);
        tbl[25] = mk(1,1,0,0,1, 1,0,0,1,0,4);
        tbl[26] = mk(1,1,0,0,1, 1,0,0,0,0,4);
        tbl[27] = mk(1,1,0,0,1, 1,0,1,1,0,3);

        for (int i = 0; i < 28; i++) begin
            resetn = tbl[i].rst_n; enable = tbl[i].en; cfg_valid = tbl[i].vld;
            cfg_step = tbl[i].step; cfg_dir = tbl[i].dir;
            tick();
            chk($sformatf("vec%0d {ready,SA,SB,pulse,index,pos}", i),
                {23'b0, cfg_ready, SA, SB, step_pulse, index, position},
                {23'b0, tbl[i].ready, tbl[i].sa, tbl[i].sb, tbl[i].pulse, tbl[i].idx, tbl[i].pos});
        end
        cfg_valid = 1'b0;

        // Index and position wrap at step=1: 8 forward edges, then one reverse edge.
        do_reset();
        cfg(1, 1);
        enable = 1'b1;
        tick();
        chk("step1 no edge on enable sample", 32'(step_pulse), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("step1 pulse edge%0d", k), 32'(step_pulse), 32'd1);
            chk($sformatf("step1 index edge%0d", k), 32'(index), (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("step1 position edge%0d", k), 32'(position), 32'(k & 15));
        end
        enable = 1'b0;
        tick();
        chk("disable no edge", {30'b0, step_pulse, 1'b0} | 32'(position), 32'h8);
        cfg(1, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("reverse edge {pulse,idx,SA,SB,pos}",
            {25'b0, step_pulse, index, SA, SB, position}, {25'b0, 1'b1, 1'b0, 2'b01, 4'd7});
        enable = 1'b0;

        // Enable dropped one clock before an edge is due; re-enable restarts a full interval.
        do_reset();
        cfg(3, 1);
        enable = 1'b1;
        tick(); tick(); tick();
        enable = 1'b0;
        tick();
        chk("dropped enable {pulse,SA,SB,pos}", {25'b0, step_pulse, SA, SB, position}, 32'h0);
        tick();
        chk("idle hold pulse", 32'(step_pulse), 32'd0);
        enable = 1'b1;
        tick();
        c = 0;
        do begin
            tick();
            c++;
        end while (!step_pulse && c < 10);
        chk("re-enable latency", 32'(c), 32'd3);
        chk("re-enable edge {SA,SB}", {30'b0, SA, SB}, 32'b10);

        // Step 0 while running: the in-flight interval finishes, then the phase freezes.
        cfg(0, 1);
        c = 0;
        while (!step_pulse && c < 10) begin
            tick();
            c++;
        end
        chk("step0 apply edge seen", 32'(step_pulse), 32'd1);
        chk("step0 apply edge {ready,SA,SB,pos}", {27'b0, cfg_ready, SA, SB, position},
            {27'b0, 1'b1, 2'b11, 4'd2});
        np = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (step_pulse) np++;
        end
        chk("step0 pulses in 100 clks", 32'(np), 32'd0);
        chk("step0 frozen {SA,SB,pos}", {26'b0, SA, SB, position}, {26'b0, 2'b11, 4'd2});

        // Asynchronous reset mid-interval with a configuration in flight.
        cfg(4, 1);
        c = 0;
        while (!step_pulse && c < 10) begin
            tick();
            c++;
        end
        chk("step4 edge {pulse,SA,SB,pos}", {25'b0, step_pulse, SA, SB, position},
            {25'b0, 1'b1, 2'b01, 4'd3});
        cfg_valid = 1'b1; cfg_step = 8'd7; cfg_dir = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("in-flight cfg ready low", 32'(cfg_ready), 32'd0);
        #3;
        resetn = 1'b0;
        #1;
        chk("async reset {ready,idx,pulse,SA,SB,pos}",
            {24'b0, cfg_ready, index, step_pulse, SA, SB, position}, {24'b0, 5'b11000, 4'd0});
        tick();
        resetn = 1'b1;
        enable = 1'b1;
        np = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (step_pulse) np++;
        end
        chk("lost cfg no pulses", 32'(np), 32'd0);
        chk("lost cfg ready", 32'(cfg_ready), 32'd1);
        enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
